nn_sequencer: RTL and testbench

Time-multiplexed controller for the intent classifier's dense output layer. It buffers a 16-feature IEEE-754 single-precision vector and steps one shared pipelined floating-point MAC unit through every output neuron, fetching weights and biases from a weight ROM. It collects the logits and emits them with an argmax class index. It sits between the feature-extraction front end (valid/ready stream) and the result consumer, and replaces one full combinational neuron per output.

---
 rtl/nn_sequencer.sv | 167 ++++++++++++++++
 tb/tb_nn_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer.sv
// Time-multiplexed sequencer for a dense output layer: buffers one feature vector,
// steps a shared pipelined FP MAC through every neuron, and returns logits plus argmax.
module nn_sequencer #(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 2,
  parameter int MAC_LAT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [31:0]                           in_data,
  output logic [$clog2(N_OUT*(N_IN+1))-1:0]     w_addr,
  input  logic [31:0]                           w_data,
  output logic                                  mac_clr,
  output logic                                  mac_en,
  output logic [31:0]                           mac_x,
  output logic [31:0]                           mac_w,
  input  logic [31:0]                           mac_acc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [32*N_OUT-1:0]                   out_logits,
  output logic [$clog2(N_OUT)-1:0]              out_class,
  output logic                                  busy
);

  localparam int AW = $clog2(N_OUT*(N_IN+1));
  localparam int CW = $clog2(N_OUT);
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
  localparam logic [CW-1:0] J_LAST = CW'(N_OUT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_BIAS, S_CLR, S_MAC, S_DRAIN, S_STORE, S_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [CW-1:0]             j_q, j_d;
  logic [DW-1:0]             d_q, d_d;
  logic [31:0]               feat_q [N_IN];
  logic [N_OUT-1:0][31:0]    logits_q;
  logic [31:0]               best_q;
  logic [CW-1:0]             best_idx_q;
  logic [CW-1:0]             class_q;
  logic [AW-1:0]             base;
  logic                      load_hs;
  logic                      take_new;

  // IEEE-754 "a > b" for non-NaN values; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
    ka = a[31] ? ~a : {1'b1, a[30:0]};
    kb = b[31] ? ~b : {1'b1, b[30:0]};
    return ka > kb;
  endfunction

  assign load_hs  = (state_q == S_LOAD) && in_valid;
  assign base     = AW'(j_q) * AW'(N_IN + 1);
  assign take_new = (j_q == '0) || fp_gt(mac_acc, best_q);

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      j_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      d_q     <= d_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    d_d     = d_q;
    unique case (state_q)
      S_LOAD: if (load_hs) begin
        k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        if (k_q == K_LAST) begin
          j_d     = '0;
          state_d = S_BIAS;
        end
      end
      S_BIAS:  state_d = S_CLR;
      S_CLR:   state_d = S_MAC;
      S_MAC: begin
        k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        if (k_q == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        if (d_q == D_LAST) state_d = S_STORE;
      end
      S_STORE: begin
        if (j_q == J_LAST) begin
          state_d = S_OUT;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_BIAS;
        end
      end
      S_OUT:   if (out_ready) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == S_LOAD);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_LOAD);
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_x     = '0;
    mac_w     = w_data;
    w_addr    = '0;
    unique case (state_q)
      S_BIAS: w_addr = base + AW'(N_IN);
      S_CLR: begin
        mac_clr = 1'b1;
        w_addr  = base;
      end
      S_MAC: begin
        mac_en = 1'b1;
        mac_x  = feat_q[k_q];
        w_addr = base + AW'(k_q) + AW'(1);
      end
      default: ;
    endcase
  end

  // NOTE: the feature buffer has no reset; it is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (rst_n && load_hs) feat_q[k_q] <= in_data;
  end

  // Running argmax: strict greater-than keeps ties on the lower neuron index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      logits_q   <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
    end else if (state_q == S_STORE) begin
      logits_q[j_q] <= mac_acc;
      if (take_new) begin
        best_q     <= mac_acc;
        best_idx_q <= j_q;
      end
      if (j_q == J_LAST) class_q <= take_new ? j_q : best_idx_q;
    end
  end

  assign out_logits = logits_q;
  assign out_class  = class_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer: ROM and pipelined MAC models, an address/strobe
// protocol monitor, and hand-computed logits and class for each vector.
module tb_nn_sequencer;

  localparam int N_IN    = 16;
  localparam int N_OUT   = 2;
  localparam int MAC_LAT = 4;
  localparam int AW      = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_ready, out_valid, busy, mac_clr, mac_en;
  logic [31:0]   w_data, mac_x, mac_w, mac_acc;
  logic [AW-1:0] w_addr;
  logic [63:0]   out_logits;
  logic          out_class;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int          cyc = 0;

  nn_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_x(mac_x), .mac_w(mac_w), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_logits(out_logits),
    .out_class(out_class), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    man = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e + 127), man};
  endfunction

  // Weight ROM with one cycle read latency.
  logic [31:0] rom [N_OUT*(N_IN+1)];
  always @(posedge clk) w_data <= rom[w_addr];

  task automatic set_rom(input logic [31:0] w0, input logic [31:0] b0,
                         input logic [31:0] w1, input logic [31:0] b1);
    for (int i = 0; i < N_IN; i++) begin
      rom[i]          = w0;
      rom[N_IN+1 + i] = w1;
    end
    rom[N_IN]       = b0;
    rom[2*N_IN + 1] = b1;
  endtask

  // MAC model: zero products leave the accumulator bits untouched so a -0 bias survives.
  real         acc_r_q = 0.0, acc_r_d, prod;
  logic [31:0] acc_b_q = '0, acc_b_d;
  logic [31:0] pipe_q [MAC_LAT];

  always_comb begin
    acc_r_d = acc_r_q;
    acc_b_d = acc_b_q;
    prod    = 0.0;
    if (mac_clr) begin
      acc_r_d = f2r(mac_w);
      acc_b_d = mac_w;
    end else if (mac_en) begin
      prod = f2r(mac_x) * f2r(mac_w);
      if (prod != 0.0) begin
        acc_r_d = acc_r_q + prod;
        acc_b_d = r2f(acc_r_q + prod);
      end
    end
  end

  always @(posedge clk) begin
    acc_r_q   <= acc_r_d;
    acc_b_q   <= acc_b_d;
    pipe_q[0] <= acc_b_d;
    for (int i = 1; i < MAC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign mac_acc = pipe_q[MAC_LAT-1];

  // Protocol monitor: address order, strobe exclusivity, operand order, ready during compute.
  logic [31:0]   cur_feat [N_IN];
  int            mon_en = 0, mon_clr = 0, mon_j = 0, mon_k = 0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n || (out_valid && out_ready)) begin
      mon_en  <= 0;
      mon_clr <= 0;
      mon_j   <= 0;
      mon_k   <= 0;
    end else begin
      if (mac_clr || mac_en) check("strobe_excl", 96'(mac_clr & mac_en), 96'(0));
      if (mac_clr) begin
        check("bias_addr", 96'(prev_addr), 96'(mon_j*17 + 16));
        check("clr_addr", 96'(w_addr), 96'(mon_j*17));
        mon_clr <= mon_clr + 1;
        mon_k   <= 0;
      end
      if (mac_en) begin
        check("mac_x", 96'(mac_x), 96'(cur_feat[mon_k % N_IN]));
        if (mon_k < N_IN-1) check("mac_addr", 96'(w_addr), 96'(mon_j*17 + mon_k + 1));
        else mon_j <= mon_j + 1;
        mon_k  <= mon_k + 1;
        mon_en <= mon_en + 1;
      end
      if (busy) check("ready_busy", 96'(in_ready), 96'(0));
    end
    prev_addr <= w_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (cycles) tick();
    @(negedge clk);
    check("rst_ctrl", 96'({in_ready, out_valid, busy, mac_clr, mac_en, out_class, w_addr}), 96'(0));
    check("rst_logits", 96'(out_logits), 96'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 96'({in_ready, busy}), 96'({1'b1, 1'b0}));
    tick();
  endtask

  task automatic load_vector(input bit gaps, output int c_last);
    bit acc;
    int budget;
    c_last = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = cur_feat[i];
      acc      = 1'b0;
      budget   = 0;
      while (!acc && budget < 100) begin
        @(negedge clk);
        acc    = in_ready;
        c_last = cyc;
        tick();
        budget++;
      end
      if (!acc) check("load_timeout", 96'(acc), 96'(1));
    end
    in_valid = 1'b1;           // junk beats during compute must be ignored
    in_data  = 32'hdeadbeef;
  endtask

  task automatic await_result(input int c_last, input int hold, input logic [63:0] exp_logits,
                              input logic exp_cls, input string tag);
    int budget = 0;
    out_ready = (hold == 0);
    @(negedge clk);
    while (!out_valid && budget < 200) begin
      tick();
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    check({tag, "_valid"},   96'(out_valid), 96'(1));
    check({tag, "_latency"}, 96'(cyc - c_last), 96'(47));
    check({tag, "_logits"},  96'(out_logits), 96'(exp_logits));
    check({tag, "_class"},   96'(out_class), 96'(exp_cls));
    check({tag, "_en_clr"},  96'({mon_en, mon_clr}), 96'({32'd32, 32'd2}));
    for (int h = 1; h <= hold; h++) begin
      tick();
      if (h == hold) out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_hold"}, 96'({out_valid, in_ready, out_class, out_logits}),
            96'({1'b1, 1'b0, exp_cls, exp_logits}));
    end
    tick();
    @(negedge clk);
    check({tag, "_next_ready"}, 96'({out_valid, in_ready, busy}), 96'({1'b0, 1'b1, 1'b0}));
    tick();
  endtask

  task automatic fill_feat(input logic [31:0] v);
    for (int i = 0; i < N_IN; i++) cur_feat[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    set_rom(32'h3f800000, 32'h00000000, 32'hbf800000, 32'h40000000);
    fill_feat(32'h3f800000);
    do_reset(3);

    // 16*1 + 0 = 16.0 ; 16*(-1) + 2 = -14.0
    load_vector(1'b0, c);
    await_result(c, 0, {32'hc1600000, 32'h41800000}, 1'b0, "basic");

    fill_feat(32'h00000000);
    load_vector(1'b0, c);
    await_result(c, 0, {32'h40000000, 32'h00000000}, 1'b1, "zero_feat");

    fill_feat(32'h3f800000);
    load_vector(1'b0, c);
    await_result(c, 10, {32'hc1600000, 32'h41800000}, 1'b0, "backpressure");

    load_vector(1'b1, c);
    await_result(c, 0, {32'hc1600000, 32'h41800000}, 1'b0, "gaps");

    // Features 0..15: sum = 120.0 ; 2 - 120 = -118.0
    for (int i = 0; i < N_IN; i++) cur_feat[i] = r2f(real'(i));
    load_vector(1'b1, c);
    await_result(c, 3, {32'hc2ec0000, 32'h42f00000}, 1'b0, "ramp");

    // +0 versus -0 is a tie and must resolve to neuron 0
    set_rom(32'h3f800000, 32'h00000000, 32'hbf800000, 32'h80000000);
    fill_feat(32'h00000000);
    load_vector(1'b0, c);
    await_result(c, 0, {32'h80000000, 32'h00000000}, 1'b0, "tie");

    // -1.0 beats -3.0
    set_rom(32'h3f800000, 32'hbf800000, 32'h3f800000, 32'hc0400000);
    load_vector(1'b0, c);
    await_result(c, 0, {32'hc0400000, 32'hbf800000}, 1'b0, "negatives");

    // Reset in the middle of neuron 1's MAC phase, then a clean vector
    set_rom(32'h3f800000, 32'h00000000, 32'hbf800000, 32'h40000000);
    fill_feat(32'h3f800000);
    load_vector(1'b0, c);
    repeat (30) tick();
    do_reset(1);
    check("rst_mon_clear", 96'({mon_en, mon_clr}), 96'(0));
    load_vector(1'b0, c);
    await_result(c, 0, {32'hc1600000, 32'h41800000}, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
